avg_iq_accumulator: RTL and testbench

Fabric-side IQ averaging stage for the channeliser readout. It integrates a stream of signed I/Q samples over 2^L samples and writes each averaged I/Q pair into a capture BRAM. It publishes its progress as a 32-bit status word for the PPC-readable `avgIQ_addr` software register, which samples it on `user_clk`. Software arms a capture, polls the status word until the busy flag clears, then reads the BRAM.

---
 rtl/avg_iq_accumulator.sv | 143 ++++++++++++++
 tb/tb_avg_iq_accumulator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/avg_iq_accumulator.sv
// Integrates signed I/Q samples over 2^L samples per word and writes each averaged
// pair into a capture BRAM, publishing {busy, words completed} as a status word.
module avg_iq_accumulator #(
  parameter int DATA_W       = 16,
  parameter int LOG2_MAX_LEN = 16,
  parameter int ADDR_W       = 10
) (
  input  logic                     user_clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  input  logic                     ctrl_start,
  input  logic                     ctrl_stop,
  input  logic [4:0]               ctrl_log2_len,
  output logic                     bram_we,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [31:0]              bram_data,
  output logic                     busy,
  output logic [31:0]              avg_addr
);

  localparam int ACC_W = DATA_W + LOG2_MAX_LEN;
  localparam int CNT_W = LOG2_MAX_LEN + 1;
  localparam int PAD_W = 31 - (ADDR_W + 1);
  localparam logic [4:0]        MAX_LEN   = 5'(LOG2_MAX_LEN);
  localparam logic [ADDR_W:0]   LAST_WORD = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   WORD_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_reg, state_next;
  logic              start_q_reg, start_armed_reg, start_edge, start_go;
  logic [4:0]        log2_len_reg, len_clamped;
  logic [CNT_W-1:0]  cnt_reg, last_cnt;
  logic [ADDR_W:0]   word_cnt_reg, word_cnt_next;
  logic              accept, word_done, final_write;
  logic              bram_we_reg, busy_reg, busy_next;
  logic [31:0]       avg_addr_reg, avg_pair;

  // A start level already high when reset releases is treated as held, not as a new edge.
  assign start_edge  = ctrl_start & ~start_q_reg & start_armed_reg;
  assign len_clamped = (ctrl_log2_len > MAX_LEN) ? MAX_LEN : ctrl_log2_len;
  assign last_cnt    = ~({CNT_W{1'b1}} << log2_len_reg);
  assign final_write = bram_we_reg && (word_cnt_reg == LAST_WORD);

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    start_go      = 1'b0;
    accept        = 1'b0;
    word_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          start_go   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // Stop beats a coinciding final sample; the last write's cycle also ends the run.
        if (ctrl_stop || final_write) begin
          state_next = IDLE;
        end else if (in_valid) begin
          accept    = 1'b1;
          word_done = (cnt_reg == last_cnt);
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next     = (state_next == RUN);
    word_cnt_next = word_cnt_reg;
    if (start_go)         word_cnt_next = '0;
    else if (bram_we_reg) word_cnt_next = word_cnt_reg + WORD_ONE;
  end

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q_reg     <= 1'b0;
      start_armed_reg <= 1'b0;
      log2_len_reg    <= '0;
      cnt_reg         <= '0;
      word_cnt_reg    <= '0;
      bram_we_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      avg_addr_reg    <= '0;
    end else begin
      start_q_reg     <= ctrl_start;
      start_armed_reg <= start_armed_reg | ~ctrl_start;
      if (start_go) begin
        log2_len_reg <= len_clamped;
        cnt_reg      <= '0;
      end else if (accept) begin
        cnt_reg <= word_done ? '0 : cnt_reg + CNT_ONE;
      end
      bram_we_reg  <= word_done;
      word_cnt_reg <= word_cnt_next;
      busy_reg     <= busy_next;
      // Built from next-state values so every status bit moves on the same edge.
      avg_addr_reg <= {busy_next, {PAD_W{1'b0}}, word_cnt_next};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [DATA_W-1:0] sample;
      logic signed [ACC_W-1:0]  acc_reg, sum;
      logic [15:0]              avg_trunc, avg_reg;

      assign sample    = (gi == 0) ? in_i : in_q;
      assign sum       = acc_reg + ACC_W'(sample);
      assign avg_trunc = 16'(sum >>> log2_len_reg);

      always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg <= '0;
          avg_reg <= '0;
        end else begin
          if (start_go)    acc_reg <= '0;
          else if (accept) acc_reg <= word_done ? '0 : sum;
          if (word_done)   avg_reg <= avg_trunc;
        end
      end

      // I occupies the upper half of the BRAM word, Q the lower half.
      assign avg_pair[31-16*gi -: 16] = avg_reg;
    end
  endgenerate

  assign bram_we   = bram_we_reg;
  assign bram_addr = word_cnt_reg[ADDR_W-1:0];
  assign bram_data = avg_pair;
  assign busy      = busy_reg;
  assign avg_addr  = avg_addr_reg;

endmodule

// File: tb/tb_avg_iq_accumulator.sv
// Directed bench for avg_iq_accumulator: averaging, addressing, stop, reset and clamp cases
// with hand-computed expected words.
module tb_avg_iq_accumulator;

  localparam int DATA_W       = 16;
  localparam int LOG2_MAX_LEN = 16;
  localparam int ADDR_W       = 3;

  logic              user_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [15:0]       in_i = '0;
  logic [15:0]       in_q = '0;
  logic              ctrl_start = 1'b0;
  logic              ctrl_stop = 1'b0;
  logic [4:0]        ctrl_log2_len = '0;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_data;
  logic              busy;
  logic [31:0]       avg_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int base;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  avg_iq_accumulator #(
    .DATA_W(DATA_W), .LOG2_MAX_LEN(LOG2_MAX_LEN), .ADDR_W(ADDR_W)
  ) dut (
    .user_clk(user_clk), .rst_n(rst_n), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .ctrl_log2_len(ctrl_log2_len),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_data(bram_data),
    .busy(busy), .avg_addr(avg_addr)
  );

  always #5 user_clk = ~user_clk;

  always @(negedge user_clk) begin
    if (bram_we) begin
      wr_addr_q.push_back(32'(bram_addr));
      wr_data_q.push_back(bram_data);
      $display("write addr=%0d data=0x%08h", bram_addr, bram_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic sample(input logic v, input logic [15:0] i, input logic [15:0] q);
    in_valid = v;
    in_i     = i;
    in_q     = q;
    tick();
  endtask

  task automatic start_cap(input logic [4:0] l);
    in_valid      = 1'b0;
    ctrl_log2_len = l;
    ctrl_start    = 1'b1;
    tick();
    ctrl_start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic stop_cap();
    in_valid  = 1'b0;
    ctrl_stop = 1'b1;
    tick();
    ctrl_stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_we", 32'(bram_we), 32'd0);
    check("rst_addr", 32'(bram_addr), 32'd0);
    check("rst_data", bram_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_avg_addr", avg_addr, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // L=2: I sum 40 -> 10, Q sum -10 -> floor(-2.5) = -3
    start_cap(5'd2);
    base = wr_addr_q.size();
    sample(1'b1, 16'd4,  16'hFFFF);
    sample(1'b1, 16'd8,  16'hFFFE);
    sample(1'b1, 16'd12, 16'hFFFD);
    sample(1'b1, 16'd16, 16'hFFFC);
    check("l2_we", 32'(bram_we), 32'd1);
    check("l2_addr", 32'(bram_addr), 32'd0);
    check("l2_data", bram_data, 32'h000AFFFD);
    sample(1'b0, 16'd0, 16'd0);
    check("l2_we_one_cycle", 32'(bram_we), 32'd0);
    check("l2_avg_addr", avg_addr, 32'h80000001);
    check("l2_nwrites", 32'(wr_addr_q.size() - base), 32'd1);
    stop_cap();
    check("stop_keeps_count", avg_addr, 32'h00000001);

    // L=0, ADDR_W=3: eight unaveraged writes, then the capture ends itself
    start_cap(5'd0);
    base = wr_addr_q.size();
    for (int k = 0; k < 8; k++) sample(1'b1, 16'(k * 100), 16'(-k));
    check("l0_last_we", 32'(bram_we), 32'd1);
    check("l0_last_addr", 32'(bram_addr), 32'd7);
    sample(1'b1, 16'h1234, 16'h1234);
    check("l0_done_busy", 32'(busy), 32'd0);
    check("l0_done_avg_addr", avg_addr, 32'h00000008);
    check("l0_no_extra_we", 32'(bram_we), 32'd0);
    sample(1'b1, 16'h1234, 16'h1234);
    sample(1'b0, 16'd0, 16'd0);
    check("l0_nwrites", 32'(wr_addr_q.size() - base), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check("l0_wr_addr", wr_addr_q[base + k], 32'(k));
      check("l0_wr_data", wr_data_q[base + k], {16'(k * 100), 16'(-k)});
    end

    // L=3 with gaps: I sum 36 -> 4, Q sum -36 -> floor(-4.5) = -5
    start_cap(5'd3);
    base = wr_addr_q.size();
    for (int k = 1; k <= 8; k++) begin
      sample(1'b1, 16'(k), 16'(-k));
      if (k == 8) begin
        check("l3_we", 32'(bram_we), 32'd1);
        check("l3_addr", 32'(bram_addr), 32'd0);
        check("l3_data", bram_data, 32'h0004FFFB);
      end else begin
        sample(1'b0, 16'h7FFF, 16'h7FFF);
      end
    end
    sample(1'b0, 16'h7FFF, 16'h7FFF);
    check("l3_nwrites", 32'(wr_addr_q.size() - base), 32'd1);
    check("l3_avg_addr", avg_addr, 32'h80000001);
    stop_cap();

    // Stop coinciding with the final sample of the second word
    start_cap(5'd2);
    base = wr_addr_q.size();
    repeat (4) sample(1'b1, 16'd1, 16'd2);
    check("stop_first_data", bram_data, 32'h00010002);
    repeat (3) sample(1'b1, 16'd5, 16'd5);
    ctrl_stop = 1'b1;
    sample(1'b1, 16'd5, 16'd5);
    ctrl_stop = 1'b0;
    check("stop_final_busy", 32'(busy), 32'd0);
    check("stop_final_we", 32'(bram_we), 32'd0);
    sample(1'b0, 16'd0, 16'd0);
    check("stop_final_we2", 32'(bram_we), 32'd0);
    check("stop_final_avg_addr", avg_addr, 32'h00000001);
    check("stop_nwrites", 32'(wr_addr_q.size() - base), 32'd1);
    ctrl_start = 1'b1;
    tick();
    check("restart_clears_count", avg_addr, 32'h80000000);

    // Reset during a write strobe, start held high across reset
    base = wr_addr_q.size();
    repeat (4) sample(1'b1, 16'd3, 16'd3);
    check("pre_rst_we", 32'(bram_we), 32'd1);
    in_valid = 1'b1;
    in_i     = 16'd7;
    rst_n    = 1'b0;
    #1;
    check("rst_mid_we", 32'(bram_we), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_data", bram_data, 32'd0);
    check("rst_mid_avg_addr", avg_addr, 32'd0);
    check("rst_mid_addr", 32'(bram_addr), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) sample(1'b1, 16'd3, 16'd3);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_nwrites", 32'(wr_addr_q.size() - base), 32'd0);
    ctrl_start = 1'b0;
    sample(1'b0, 16'd0, 16'd0);
    start_cap(5'd0);
    sample(1'b1, 16'h0042, 16'h0099);
    check("fresh_start_data", bram_data, 32'h00420099);
    check("fresh_start_addr", 32'(bram_addr), 32'd0);
    stop_cap();

    // L=20 clamps to 16: exactly 65536 samples per word
    start_cap(5'd20);
    base = wr_addr_q.size();
    repeat (65535) sample(1'b1, 16'h8000, 16'h7FFF);
    check("clamp_no_early_we", 32'(bram_we), 32'd0);
    check("clamp_no_early_writes", 32'(wr_addr_q.size() - base), 32'd0);
    sample(1'b1, 16'h8000, 16'h7FFF);
    check("clamp_we", 32'(bram_we), 32'd1);
    check("clamp_data", bram_data, 32'h80007FFF);
    sample(1'b0, 16'd0, 16'd0);
    stop_cap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
